// File: rtl/cache_def.sv
// Shared types for the direct-mapped cache and its downstream memory controller.
package cache_def;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  // Returned for reads of lines that were never written since reset.
  localparam logic [127:0] MEM_BLANK_LINE = {4{32'hDEAD_BEEF}};

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_WAIT,
    MC_RESP
  } mc_state_type;

endpackage

// File: rtl/mem_line_store.sv
// Line store: 2**IDX_W lines of 128 bits with a per-line written bit.
module mem_line_store #(
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [127:0]     wdata,
  output logic [127:0]     rdata,
  output logic             written
);

  logic [127:0]         lines [2**IDX_W];
  logic [2**IDX_W-1:0]  written_bits;

  // NOTE: the line array has no reset; the written bits alone decide whether
  // stored data is meaningful, so clearing 2**IDX_W wide words is unnecessary.
  always_ff @(posedge clk) begin
    if (we) lines[idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     written_bits      <= '0;
    else if (we) written_bits[idx] <= 1'b1;
  end

  assign rdata   = lines[idx];
  assign written = written_bits[idx];

endmodule

// File: rtl/cache_mem_ctrl.sv
// Main-memory controller/model behind the cache: fixed-latency line access,
// one-cycle ready, sticky overrun flag and read/write access counters.
module cache_mem_ctrl
  import cache_def::*;
#(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 12,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  mem_req_type      mem_req,
  output mem_data_type     mem_data,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  mc_state_type     state;
  logic [7:0]       cnt;
  logic [IDX_W-1:0] req_idx;
  logic [127:0]     req_data;
  logic             req_rw;

  logic             store_we;
  logic [127:0]     store_rdata;
  logic             store_written;
  logic             access_now;

  // Offset bits and aliasing upper bits do not select a line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req.addr[3:0], mem_req.addr[31:IDX_W+4]};

  assign access_now = (state == MC_WAIT) && (cnt == 8'd0);
  // Gated by rst so an abandoned write never reaches the store.
  assign store_we   = access_now && req_rw && !rst;

  mem_line_store #(.IDX_W(IDX_W)) u_store (
    .clk     (clk),
    .rst     (rst),
    .we      (store_we),
    .idx     (req_idx),
    .wdata   (req_data),
    .rdata   (store_rdata),
    .written (store_written)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MC_IDLE;
      cnt      <= '0;
      mem_data <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      req_idx  <= '0;
      req_data <= '0;
      req_rw   <= 1'b0;
    end else begin
      mem_data.ready <= 1'b0;
      case (state)
        MC_IDLE: begin
          if (mem_req.valid) begin
            req_idx  <= mem_req.addr[IDX_W+3:4];
            req_data <= mem_req.data;
            req_rw   <= mem_req.rw;
            cnt      <= CNT_LOAD;
            busy     <= 1'b1;
            state    <= MC_WAIT;
          end
        end
        MC_WAIT: begin
          if (mem_req.valid) overrun <= 1'b1;
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            mem_data.ready <= 1'b1;
            state          <= MC_RESP;
            if (req_rw) begin
              mem_data.data <= req_data;
              wr_cnt        <= wr_cnt + 1'b1;
            end else begin
              mem_data.data <= store_written ? store_rdata : MEM_BLANK_LINE;
              rd_cnt        <= rd_cnt + 1'b1;
            end
          end
        end
        MC_RESP: begin
          // A write-back is followed immediately by the allocate read here.
          if (mem_req.valid) begin
            req_idx  <= mem_req.addr[IDX_W+3:4];
            req_data <= mem_req.data;
            req_rw   <= mem_req.rw;
            cnt      <= CNT_LOAD;
            state    <= MC_WAIT;
          end else begin
            busy  <= 1'b0;
            state <= MC_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= MC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_cache_mem_ctrl;
  import cache_def::*;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hCAFEF00D_11223344_55667788_99AABBCC;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  mem_req_type  req4 = '0;
  mem_req_type  req1 = '0;
  mem_data_type rsp4, rsp1;
  logic         busy4, busy1, ovr4, ovr1;
  logic [15:0]  rd4, wr4, rd1, wr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_mem_ctrl #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst), .mem_req(req4), .mem_data(rsp4),
    .busy(busy4), .overrun(ovr4), .rd_cnt(rd4), .wr_cnt(wr4)
  );

  cache_mem_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_data(rsp1),
    .busy(busy1), .overrun(ovr1), .rd_cnt(rd1), .wr_cnt(wr1)
  );

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // One-cycle valid pulse driven at negedge; sampled at the following posedge.
  task automatic issue(input int which, input logic [31:0] addr,
                       input logic [127:0] data, input logic rw);
    mem_req_type r;
    r.addr = addr; r.data = data; r.rw = rw; r.valid = 1'b1;
    @(negedge clk);
    if (which == 1) req1 = r; else req4 = r;
    @(negedge clk);
    if (which == 1) req1.valid = 1'b0; else req4.valid = 1'b0;
  endtask

  // Counts posedges after the sampling edge until ready is seen.
  task automatic wait_ready(input int which, input int exp_n, input string name);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if ((which == 1) ? rsp1.ready : rsp4.ready) seen = 1'b1;
    end
    checks++;
    if (!seen || n != exp_n) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (ready seen=%0b), expected %0d", name, n, seen, exp_n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if ({rsp4, busy4, ovr4, rd4, wr4} !== '0) begin
      errors++;
      $display("FAIL reset4: got ready=%0b data=%h busy=%0b ovr=%0b rd=%0d wr=%0d, expected all 0",
               rsp4.ready, rsp4.data, busy4, ovr4, rd4, wr4);
    end
    checks++;
    if ({rsp1, busy1, ovr1, rd1, wr1} !== '0) begin
      errors++;
      $display("FAIL reset1: got ready=%0b data=%h busy=%0b ovr=%0b rd=%0d wr=%0d, expected all 0",
               rsp1.ready, rsp1.data, busy1, ovr1, rd1, wr1);
    end
  endtask

  task automatic test_blank_read();
    logic [127:0] held;
    do_reset();
    issue(0, 32'h0000_0010, '0, 1'b0);
    checks++;
    if (busy4 !== 1'b1) begin
      errors++; $display("FAIL blank_busy: got %0b, expected 1", busy4);
    end
    wait_ready(0, 4, "blank_read");
    checks++;
    if (rsp4.data !== MEM_BLANK_LINE || rd4 !== 16'd1 || wr4 !== 16'd0) begin
      errors++;
      $display("FAIL blank_read: got data=%h rd=%0d wr=%0d, expected %h rd=1 wr=0",
               rsp4.data, rd4, wr4, MEM_BLANK_LINE);
    end
    held = rsp4.data;
    @(posedge clk); #1;
    checks++;
    if (rsp4.ready !== 1'b0 || busy4 !== 1'b0 || rsp4.data !== MEM_BLANK_LINE) begin
      errors++;
      $display("FAIL blank_after: got ready=%0b busy=%0b data=%h, expected 0 0 %h",
               rsp4.ready, busy4, rsp4.data, held);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    issue(0, 32'h0000_0120, D1, 1'b1);
    wait_ready(0, 4, "write_0x120");
    checks++;
    if (rsp4.data !== D1 || wr4 !== 16'd1) begin
      errors++;
      $display("FAIL write_resp: got data=%h wr=%0d, expected %h wr=1", rsp4.data, wr4, D1);
    end
    @(posedge clk); #1;
    issue(0, 32'h0000_012C, '0, 1'b0);
    wait_ready(0, 4, "read_0x12C");
    checks++;
    if (rsp4.data !== D1 || wr4 !== 16'd1 || rd4 !== 16'd1) begin
      errors++;
      $display("FAIL raw_same_line: got data=%h wr=%0d rd=%0d, expected %h wr=1 rd=1",
               rsp4.data, wr4, rd4, D1);
    end
    @(posedge clk); #1;
    // Bits above the index alias onto the same line.
    issue(0, 32'h8001_0125, '0, 1'b0);
    wait_ready(0, 4, "read_alias");
    checks++;
    if (rsp4.data !== D1 || rd4 !== 16'd2) begin
      errors++;
      $display("FAIL alias_read: got data=%h rd=%0d, expected %h rd=2", rsp4.data, rd4, D1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(0, 32'h0000_0300, D2, 1'b1);
    wait_ready(0, 4, "wb_write");
    issue(0, 32'h0000_0300, '0, 1'b0);
    checks++;
    if (busy4 !== 1'b1) begin
      errors++; $display("FAIL b2b_busy: got %0b, expected 1", busy4);
    end
    wait_ready(0, 4, "alloc_read");
    checks++;
    if (rsp4.data !== D2 || ovr4 !== 1'b0 || wr4 !== 16'd1 || rd4 !== 16'd1) begin
      errors++;
      $display("FAIL b2b_alloc: got data=%h ovr=%0b wr=%0d rd=%0d, expected %h 0 1 1",
               rsp4.data, ovr4, wr4, rd4, D2);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp4.ready !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got ready=%0b busy=%0b, expected 0 0", rsp4.ready, busy4);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    issue(0, 32'h0000_0010, '0, 1'b0);
    checks++;
    if (ovr4 !== 1'b0) begin
      errors++; $display("FAIL ovr_pre: got %0b, expected 0", ovr4);
    end
    req4 = '{addr: 32'h0000_0500, data: D3, rw: 1'b1, valid: 1'b1};
    @(negedge clk); req4.valid = 1'b0;
    checks++;
    if (ovr4 !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got %0b, expected 1", ovr4);
    end
    wait_ready(0, 3, "ovr_orig_timing");
    checks++;
    if (rsp4.data !== MEM_BLANK_LINE || rd4 !== 16'd1 || wr4 !== 16'd0 || ovr4 !== 1'b1) begin
      errors++;
      $display("FAIL ovr_resp: got data=%h rd=%0d wr=%0d ovr=%0b, expected %h 1 0 1",
               rsp4.data, rd4, wr4, ovr4, MEM_BLANK_LINE);
    end
    @(posedge clk); #1;
    issue(0, 32'h0000_0500, '0, 1'b0);
    wait_ready(0, 4, "ovr_dropped_line");
    checks++;
    if (rsp4.data !== MEM_BLANK_LINE || ovr4 !== 1'b1) begin
      errors++;
      $display("FAIL ovr_dropped: got data=%h ovr=%0b, expected %h 1", rsp4.data, ovr4, MEM_BLANK_LINE);
    end
    @(posedge clk); #1;
  endtask

  // rst_edge: number of posedges after the sampling edge before rst is sampled.
  task automatic test_abort(input int rst_edge, input logic [31:0] addr, input string name);
    int ready_seen = 0;
    do_reset();
    issue(0, addr, D3, 1'b1);
    repeat (rst_edge - 1) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp4.ready) ready_seen++;
    end
    checks++;
    if (ready_seen != 0 || busy4 !== 1'b0 || rd4 !== 16'd0 || wr4 !== 16'd0 || ovr4 !== 1'b0) begin
      errors++;
      $display("FAIL %s_state: got readies=%0d busy=%0b rd=%0d wr=%0d ovr=%0b, expected 0 0 0 0 0",
               name, ready_seen, busy4, rd4, wr4, ovr4);
    end
    issue(0, addr, '0, 1'b0);
    wait_ready(0, 4, name);
    checks++;
    if (rsp4.data !== MEM_BLANK_LINE) begin
      errors++;
      $display("FAIL %s_line: got %h, expected %h", name, rsp4.data, MEM_BLANK_LINE);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency1();
    do_reset();
    issue(1, 32'h0000_0040, D2, 1'b1);
    wait_ready(1, 1, "lat1_write");
    checks++;
    if (rsp1.data !== D2 || wr1 !== 16'd1) begin
      errors++;
      $display("FAIL lat1_write: got data=%h wr=%0d, expected %h 1", rsp1.data, wr1, D2);
    end
    issue(1, 32'h0000_0048, '0, 1'b0);
    wait_ready(1, 1, "lat1_b2b_read");
    checks++;
    if (rsp1.data !== D2 || rd1 !== 16'd1 || ovr1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_read: got data=%h rd=%0d ovr=%0b, expected %h 1 0", rsp1.data, rd1, ovr1, D2);
    end
    issue(1, 32'h0000_0050, '0, 1'b0);
    wait_ready(1, 1, "lat1_b2b_blank");
    checks++;
    if (rsp1.data !== MEM_BLANK_LINE || rd1 !== 16'd2) begin
      errors++;
      $display("FAIL lat1_blank: got data=%h rd=%0d, expected %h 2", rsp1.data, rd1, MEM_BLANK_LINE);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp1.ready !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_idle: got ready=%0b busy=%0b, expected 0 0", rsp1.ready, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_blank_read();
    test_write_read();
    test_back_to_back();
    test_overrun();
    test_abort(2, 32'h0000_0200, "abort_wait2");
    test_abort(4, 32'h0000_0210, "abort_last_wait");
    test_latency1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
